// File: rtl/local_spike_scheduler_pkg.sv
// Shared widths and local-packet field helpers for the local spike scheduler.
// Packet layout is {dt, axon}, matching the router's stripped local output.
package local_spike_scheduler_pkg;

  localparam int unsigned NUM_AXONS_DEF = 256;
  localparam int unsigned NUM_TICKS_DEF = 16;
  localparam int unsigned AXON_W        = $clog2(NUM_AXONS_DEF);
  localparam int unsigned DT_W          = $clog2(NUM_TICKS_DEF);
  localparam int unsigned LOCAL_PKT_W   = DT_W + AXON_W;

  function automatic logic [31:0] pkt_dt(input logic [31:0] pkt, input int unsigned axon_w);
    return pkt >> axon_w;
  endfunction

  function automatic logic [31:0] pkt_axon(input logic [31:0] pkt, input int unsigned axon_w);
    return pkt & ((32'd1 << axon_w) - 32'd1);
  endfunction

endpackage

// File: rtl/local_spike_scheduler.sv
// Delay ring of future-tick axon spike vectors; each packet sets one bit,
// each tick emits and clears the current slot.
module local_spike_scheduler
  import local_spike_scheduler_pkg::*;
#(
  parameter int unsigned NUM_AXONS    = 256,
  parameter int unsigned NUM_TICKS    = 16,
  parameter int unsigned PACKET_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACKET_WIDTH-1:0] din,
  input  logic                    din_wen,
  input  logic                    tick,
  output logic [NUM_AXONS-1:0]    axon_spikes,
  output logic                    spikes_valid,
  output logic                    pending_any
);

  localparam int unsigned AXW = $clog2(NUM_AXONS);
  localparam int unsigned DTW = $clog2(NUM_TICKS);

  if (PACKET_WIDTH != DTW + AXW) begin : g_bad_packet_width
    $error("PACKET_WIDTH must equal clog2(NUM_TICKS) + clog2(NUM_AXONS)");
  end

  logic [NUM_AXONS-1:0] slots      [NUM_TICKS];
  logic [NUM_AXONS-1:0] slots_nxt  [NUM_TICKS];
  logic [DTW-1:0]       cur;
  logic [DTW-1:0]       dt;
  logic [DTW-1:0]       target;
  logic [AXW-1:0]       axon;
  logic [NUM_AXONS-1:0] axon_bit;
  logic [NUM_AXONS-1:0] emit;
  logic                 any_nxt;

  assign dt     = DTW'(pkt_dt(32'(din), AXW));
  assign axon   = AXW'(pkt_axon(32'(din), AXW));
  assign target = cur + dt;

  always_comb begin
    axon_bit       = '0;
    axon_bit[axon] = 1'b1;
    slots_nxt      = slots;
    emit           = slots[cur];
    if (din_wen) begin
      slots_nxt[target] = slots[target] | axon_bit;
    end
    // a write aimed at the slot being emitted joins this tick's vector
    if (tick) begin
      if (din_wen && (target == cur)) begin
        emit = slots[cur] | axon_bit;
      end
      slots_nxt[cur] = '0;
    end
    any_nxt = 1'b0;
    for (int i = 0; i < int'(NUM_TICKS); i++) begin
      any_nxt = any_nxt | (|slots_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_TICKS); i++) begin
        slots[i] <= '0;
      end
      cur <= '0;
    end else begin
      slots <= slots_nxt;
      if (tick) begin
        cur <= cur + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      axon_spikes  <= '0;
      spikes_valid <= 1'b0;
      pending_any  <= 1'b0;
    end else begin
      spikes_valid <= tick;
      pending_any  <= any_nxt;
      if (tick) begin
        axon_spikes <= emit;
      end
    end
  end

endmodule
